// File: rtl/mem_pkg.sv
// Memory-subsystem constants and request decode shared by the fill FSM, caches and main memory.
package mem_pkg;

    localparam int MEM_ADDR_WIDTH      = 16;
    localparam int MEM_DATA_WIDTH      = 16;
    localparam int MEM_DEFAULT_LATENCY = 4;
    localparam int MEM_WORD_SHIFT      = 1;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2
    } mem_req_e;

    function automatic mem_req_e decode_req(input logic enable, input logic wr);
        if (!enable) begin
            return REQ_IDLE;
        end
        return wr ? REQ_WRITE : REQ_READ;
    endfunction

endpackage

// File: rtl/mem_latency_pipe.sv
// LATENCY-deep valid+data shift register; the data lane is zero whenever its valid bit is clear.
module mem_latency_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY    = MEM_DEFAULT_LATENCY,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic [LATENCY-1:0]    valid_q;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            data_q[0]  <= in_valid_i ? in_data_i : '0;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_data_o  = valid_q[LATENCY-1] ? data_q[LATENCY-1] : '0;

endmodule

// File: rtl/mem_latency_model.sv
// Pipelined single-port word memory returning read data a fixed LATENCY cycles after the request.
// Optional MEM_ALIGN_CHECK_EN adds a sticky align_err flag for odd byte addresses.
module mem_latency_model
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
    parameter int LATENCY     = MEM_DEFAULT_LATENCY,
    parameter int DEPTH_WORDS = 32768
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid
`ifdef MEM_ALIGN_CHECK_EN
   ,output logic                  align_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    mem_req_e              req;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    assign req = decode_req(enable, wr);
    assign idx = IDX_W'(32'(addr[ADDR_WIDTH-1:MEM_WORD_SHIFT]) % 32'(DEPTH_WORDS));

    // Storage is deliberately not reset so contents survive a pipeline flush.
    always_ff @(posedge clk) begin
        if (rst_n && (req == REQ_WRITE)) begin
            mem_q[idx] <= data_in;
        end
    end

    assign rd_word = mem_q[idx];

    mem_latency_pipe #(
        .LATENCY    (LATENCY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (req == REQ_READ),
        .in_data_i   (rd_word),
        .out_valid_o (data_valid),
        .out_data_o  (data_out)
    );

`ifdef MEM_ALIGN_CHECK_EN
    logic align_err_q;
    logic align_err_d;

    assign align_err_d = align_err_q | (enable & addr[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign align_err = align_err_q;
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = addr[0];
`endif

endmodule
